addmod_serial: RTL and testbench

- Multi-cycle modular adder over the X448 field: z = (a + b) mod p, where p = 2^448 − 2^224 − 1.
- Companion to the combinational modular subtractor in the field-arithmetic layer. It is intended for area-constrained ladder datapaths.
- Processes the 448-bit operands LIMB bits per cycle, least significant limb first, and runs two carry chains in parallel: sum and sum−p.
- Uses valid/ready handshakes on both the input and output sides.

---
 rtl/addmod_serial.sv | 137 +++++++++++++
 tb/tb_addmod_serial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addmod_serial.sv
// Multi-cycle modular adder over GF(2^448 - 2^224 - 1), LIMB bits per cycle.
// Runs sum and sum-p carry chains in parallel and selects the reduced value at the end.
module addmod_serial #(
  parameter int LIMB = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [447:0] a,
  input  logic [447:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [447:0] z
);

  localparam int W     = 448;
  localparam int NLIMB = W / LIMB;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [W-1:0] P = {{223{1'b1}}, 1'b0, {224{1'b1}}};
  localparam logic [NLIMB-1:0][LIMB-1:0] P_LIMBS = P;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cs_q, cs_d;
  logic            bd_q, bd_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    z_q, z_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    d_q, d_d;

  logic [LIMB:0]   sum_k;
  logic [LIMB:0]   dif_k;
  logic [W-1:0]    s_sh;
  logic [W-1:0]    d_sh;
  logic            last_limb;

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    bd_d        = bd_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    d_d         = d_q;
    in_ready    = 1'b0;

    // Borrow falls out as the top bit of the LIMB+1 bit difference.
    sum_k = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, cs_q};
    dif_k = {1'b0, sum_k[LIMB-1:0]} - {1'b0, P_LIMBS[cnt_q]} - {{LIMB{1'b0}}, bd_q};
    s_sh  = W'({sum_k[LIMB-1:0], s_q} >> LIMB);
    d_sh  = W'({dif_k[LIMB-1:0], d_q} >> LIMB);
    last_limb = (cnt_q == CW'(NLIMB - 1));

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cs_d    = 1'b0;
          bd_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> LIMB;
        b_d   = b_q >> LIMB;
        s_d   = s_sh;
        d_d   = d_sh;
        cs_d  = sum_k[LIMB];
        bd_d  = dif_k[LIMB];
        cnt_d = cnt_q + CW'(1);
        if (last_limb) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          // The 449-bit sum is >= p exactly when it carried out or sum-p did not borrow.
          z_d = (sum_k[LIMB] || !dif_k[LIMB]) ? d_sh : s_sh;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cs_q        <= 1'b0;
      bd_q        <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      bd_q        <= bd_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
    end
  end

  // NOTE: the operand and partial-result shift registers have no reset; they are reloaded
  // on every accept and nothing reads them before that.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    s_q <= s_d;
    d_q <= d_d;
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;

endmodule

// File: tb/tb_addmod_serial.sv
// Self-checking bench for addmod_serial: LIMB=64 and LIMB=32 instances share stimulus,
// results compared against a plain-arithmetic (a+b) mod p reference.
module tb_addmod_serial;

  localparam logic [447:0] P = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [447:0] a;
  logic [447:0] b;
  logic         sel;  // 0 selects the LIMB=64 instance, 1 the LIMB=32 instance

  logic         in_ready64, out_valid64, in_ready32, out_valid32;
  logic [447:0] z64, z32;
  logic         in_ready_m, out_valid_m;
  logic [447:0] z_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addmod_serial #(.LIMB(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel),
    .in_ready  (in_ready64),
    .a         (a),
    .b         (b),
    .out_valid (out_valid64),
    .out_ready (out_ready & ~sel),
    .z         (z64)
  );

  addmod_serial #(.LIMB(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel),
    .in_ready  (in_ready32),
    .a         (a),
    .b         (b),
    .out_valid (out_valid32),
    .out_ready (out_ready & sel),
    .z         (z32)
  );

  assign in_ready_m  = sel ? in_ready32  : in_ready64;
  assign out_valid_m = sel ? out_valid32 : out_valid64;
  assign z_m         = sel ? z32         : z64;

  function automatic logic [447:0] model(input logic [447:0] x, input logic [447:0] y);
    logic [448:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[447:0];
  endfunction

  function automatic logic [447:0] rand_fe();
    logic [447:0] v;
    for (int i = 0; i < 14; i++) v[i*32 +: 32] = $urandom();
    if (v >= P) v = v - P;
    if ($urandom_range(0, 7) == 0) v = P - 448'd1 - 448'($urandom_range(0, 3));
    return v;
  endfunction

  function automatic int latency();
    return sel ? 14 : 7;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0 || z_m !== 448'd0) begin
      n_err++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b z=%h, want 0/0/0", in_ready_m, out_valid_m, z_m);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready_m !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready_m);
    end
  endtask

  // One full operation: accept, RUN (with junk in_valid), optional DONE stall, release.
  task automatic run_op(input logic [447:0] av, input logic [447:0] bv, input int stall, input string name);
    logic [447:0] exp_z, z_hold;
    int           cyc;
    bit           bad_rdy, bad_hold;
    exp_z     = model(av, bv);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready_m !== 1'b1) begin
      n_err++;
      $display("FAIL %s/in_ready_idle: got %b want 1", name, in_ready_m);
    end
    @(posedge clk); #1;
    a = ~av;
    b = ~bv;
    cyc = 0;
    bad_rdy = 1'b0;
    while (out_valid_m !== 1'b1 && cyc < 64) begin
      if (in_ready_m !== 1'b0) bad_rdy = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != latency()) begin
      n_err++;
      $display("FAIL %s/latency: got %0d cycles want %0d", name, cyc, latency());
    end
    n_cmp++;
    if (bad_rdy || in_ready_m !== 1'b0) begin
      n_err++;
      $display("FAIL %s/in_ready_busy: in_ready seen high during RUN/DONE, want 0", name);
    end
    n_cmp++;
    if (z_m !== exp_z) begin
      n_err++;
      $display("FAIL %s/z: got %h want %h", name, z_m, exp_z);
    end
    z_hold   = z_m;
    bad_hold = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (out_valid_m !== 1'b1 || z_m !== z_hold || in_ready_m !== 1'b0) bad_hold = 1'b1;
    end
    if (stall > 0) begin
      n_cmp++;
      if (bad_hold) begin
        n_err++;
        $display("FAIL %s/backpressure: out_valid=%b z=%h, want 1 and %h held", name, out_valid_m, z_m, z_hold);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      n_err++;
      $display("FAIL %s/release: out_valid=%b in_ready=%b want 0/1", name, out_valid_m, in_ready_m);
    end
  endtask

  task automatic test_directed();
    logic [447:0] va[8];
    logic [447:0] vb[8];
    logic [447:0] one;
    one   = 448'd1;
    va[0] = 448'd1;          vb[0] = 448'd2;
    va[1] = P - one;         vb[1] = one;
    va[2] = P - one;         vb[2] = P - one;
    va[3] = 448'd0;          vb[3] = 448'd0;
    va[4] = one << 447;      vb[4] = one << 447;
    va[5] = (one << 64) - one; vb[5] = one;
    va[6] = one << 224;      vb[6] = 448'd0 - (one << 225) - 448'd2;
    va[7] = 448'd5;          vb[7] = 448'd7;
    for (int i = 0; i < 8; i++) run_op(va[i], vb[i], (i == 0) ? 5 : 0, $sformatf("dir%0d_l%0d", i, sel ? 32 : 64));
    // A few results pinned to hand-derived constants, independent of the model.
    run_op(one << 447, one << 447, 0, "carry_out");
    n_cmp++;
    if (z_m !== (one << 224) + one) begin
      n_err++;
      $display("FAIL carry_out_const: got %h want 2^224+1", z_m);
    end
    run_op(P - one, P - one, 0, "pm1_pm1");
    n_cmp++;
    if (z_m !== P - 448'd2) begin
      n_err++;
      $display("FAIL pm1_pm1_const: got %h want p-2", z_m);
    end
  endtask

  task automatic test_reset_mid();
    rst      = 1'b0;
    a        = 448'h1234_5678_9abc_def0;
    b        = 448'h0fed_cba9_8765_4321;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_m !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_ready: in_ready=%b want 0 while rst high", in_ready_m);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < latency() + 3; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (out_valid_m !== 1'b0 || z_m !== 448'd0 || in_ready_m !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b z=%h in_ready=%b want 0/0/1", out_valid_m, z_m, in_ready_m);
    end
    run_op(448'd5, 448'd7, 0, "after_reset");
  endtask

  task automatic test_reset_vs_valid();
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 448'd3;
    b        = 448'd4;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wins: in_ready=%b out_valid=%b want 1/0", in_ready_m, out_valid_m);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_op(rand_fe(), rand_fe(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
             $sformatf("rand%0d_l%0d", i, sel ? 32 : 64));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_reset_vs_valid();
    test_random(1000);
    sel = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_reset_mid();
    test_random(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
